// File: rtl/softmax_pkg.sv
// rtl/softmax_pkg.sv - shared constants and state type for the log-domain softmax helpers
//
// LN2      : ln(2) in unsigned 0.16
// LN_LUT   : LN_LUT[i] = ln(1 + 2^-i) in unsigned 0.16, i = 1..15 (entry 0 unused)
// ln_state_t : state encoding for ln_iter_block_16
package softmax_pkg;

    localparam logic [15:0] LN2 = 16'hB172;

    localparam logic [15:0] LN_LUT [16] = '{
        16'h0000, 16'h67CD, 16'h3920, 16'h1E27,
        16'h0F85, 16'h07E1, 16'h03F8, 16'h01FE,
        16'h0100, 16'h0080, 16'h0040, 16'h0020,
        16'h0010, 16'h0008, 16'h0004, 16'h0002
    };

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        ITER = 2'd2,
        OUT  = 2'd3
    } ln_state_t;

endpackage

// File: rtl/ln_iter_block_16_lod.sv
// rtl/ln_iter_block_16_lod.sv - combinational leading-one detector for a 24-bit word
//
// Module lod_24
//   data_i : 24-bit word to scan
//   pos_o  : bit index of the most significant one (0 when data_i is zero)
//   zero_o : high when data_i has no bits set
module lod_24 (
    input  logic [23:0] data_i,
    output logic [4:0]  pos_o,
    output logic        zero_o
);

    always_comb begin
        pos_o = 5'd0;
        // Ascending scan: the last hit is the highest set bit.
        for (int i = 0; i < 24; i++) begin
            if (data_i[i]) begin
                pos_o = 5'(i);
            end
        end
        zero_o = (data_i == 24'd0);
    end

endmodule

// File: rtl/ln_iter_block_16.sv
// rtl/ln_iter_block_16.sv - iterative natural log of an unsigned 8.16 sum
//
// Computes ln(x) by normalising x = 2^k * m, m in [1,2), then driving m towards
// 2.0 with multiplicative factors (1 + 2^-i); the accepted factors' logs sum
// to ln(2/m), so ln(x) = k*ln2 + ln2 - acc.
//
// Optional macro LN_ROUND_EN: round half-up at bit 7 and clamp positive
// overflow to 16'h7FFF; otherwise the result is truncated.
//
// Ports
//   clock_i         : clock, rising edge
//   reset_i         : synchronous active-high reset
//   ln_data_i       : unsigned 8.16 input
//   ln_data_valid_i : qualifies ln_data_i (ignored while busy)
//   ln_busy_o       : high whenever an operation is in flight
//   ln_data_o       : signed 1.7.8 result, held between pulses; 16'h8000 for zero input
//   ln_data_valid_o : one-cycle pulse qualifying ln_data_o
//   ln_done_o       : sticky after the first result until reset
module ln_iter_block_16 #(
    parameter int data_size = 16,
    parameter int sum_size  = 24,
    parameter int iter_num  = 12
) (
    input  logic                 clock_i,
    input  logic                 reset_i,
    input  logic [sum_size-1:0]  ln_data_i,
    input  logic                 ln_data_valid_i,
    output logic                 ln_busy_o,
    output logic [data_size-1:0] ln_data_o,
    output logic                 ln_data_valid_o,
    output logic                 ln_done_o
);

    import softmax_pkg::*;

    localparam logic [3:0] ITER_LAST = 4'(iter_num);

    ln_state_t         state_q, state_d;
    logic [23:0]       x_q;
    logic [23:0]       m_q;
    logic signed [4:0] k_q;
    logic [16:0]       acc_q;
    logic [3:0]        iter_q;
    logic              sat_q;

    logic [4:0]         lod_pos;
    logic               lod_zero;
    logic [24:0]        t_sum;
    logic signed [24:0] res;
    logic [15:0]        out_val;

    lod_24 u_lod (
        .data_i (x_q),
        .pos_o  (lod_pos),
        .zero_o (lod_zero)
    );

    // m is 1.23; bit 24 of the sum flags t >= 2.0.
    assign t_sum = {1'b0, m_q} + ({1'b0, m_q} >> iter_q);

    // Signed 8.16 result in 25 bits: k*LN2 + (LN2 - acc).
    assign res = $signed({{20{k_q[4]}}, k_q}) * $signed({9'd0, LN2})
               + $signed({9'd0, LN2})
               - $signed({8'd0, acc_q});

`ifdef LN_ROUND_EN
    logic signed [24:0] res_rnd;
    assign res_rnd = res + 25'sd128;
    assign out_val = (!res_rnd[24] && res_rnd[23]) ? 16'h7FFF : res_rnd[23:8];
`else
    assign out_val = res[23:8];
`endif

    assign ln_busy_o = (state_q != IDLE);

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (ln_data_valid_i) state_d = NORM;
            NORM: state_d = lod_zero ? OUT : ITER;
            ITER: if (iter_q == ITER_LAST) state_d = OUT;
            OUT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            x_q             <= '0;
            m_q             <= '0;
            k_q             <= '0;
            acc_q           <= '0;
            iter_q          <= '0;
            sat_q           <= 1'b0;
            ln_data_o       <= '0;
            ln_data_valid_o <= 1'b0;
            ln_done_o       <= 1'b0;
        end else begin
            ln_data_valid_o <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (ln_data_valid_i) begin
                        x_q   <= ln_data_i;
                        sat_q <= 1'b0;
                    end
                end
                NORM: begin
                    k_q    <= $signed(lod_pos - 5'd16);
                    m_q    <= x_q << (5'd23 - lod_pos);
                    acc_q  <= '0;
                    iter_q <= 4'd1;
                    sat_q  <= lod_zero;
                end
                ITER: begin
                    if (!t_sum[24]) begin
                        m_q   <= t_sum[23:0];
                        acc_q <= acc_q + {1'b0, LN_LUT[iter_q]};
                    end
                    iter_q <= iter_q + 4'd1;
                end
                OUT: begin
                    ln_data_o       <= sat_q ? 16'h8000 : out_val;
                    ln_data_valid_o <= 1'b1;
                    ln_done_o       <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ln_iter_block_16.sv
// tb/tb_ln_iter_block_16.sv - directed self-checking bench for ln_iter_block_16
module tb_ln_iter_block_16;

    logic        clock_i = 1'b0;
    logic        reset_i = 1'b1;
    logic [23:0] ln_data_i = '0;
    logic        ln_data_valid_i = 1'b0;
    logic        ln_busy_o;
    logic [15:0] ln_data_o;
    logic        ln_data_valid_o;
    logic        ln_done_o;

    int checks = 0;
    int failures = 0;

`ifdef LN_ROUND_EN
    localparam logic [15:0] EXP_FULL = 16'h058C;
`else
    localparam logic [15:0] EXP_FULL = 16'h058B;
`endif

    ln_iter_block_16 dut (
        .clock_i         (clock_i),
        .reset_i         (reset_i),
        .ln_data_i       (ln_data_i),
        .ln_data_valid_i (ln_data_valid_i),
        .ln_busy_o       (ln_busy_o),
        .ln_data_o       (ln_data_o),
        .ln_data_valid_o (ln_data_valid_o),
        .ln_done_o       (ln_done_o)
    );

    always #5 clock_i = ~clock_i;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp, input int tol = 0);
        logic signed [15:0] d;
        logic ok;
        checks++;
        d  = $signed(got[15:0] - exp[15:0]);
        ok = (tol == 0) ? (got == exp) : (int'(d) >= -tol && int'(d) <= tol);
        if (!ok) begin
            failures++;
            $display("FAIL %s got=%h exp=%h tol=%0d", tag, got, exp, tol);
        end
    endtask

    // Called at posedge+1; returns at the capture edge +1.
    task automatic send(input logic [23:0] x);
        ln_data_i       = x;
        ln_data_valid_i = 1'b1;
        @(posedge clock_i);
        #1;
        ln_data_valid_i = 1'b0;
    endtask

    // Counts edges after the capture edge until the valid pulse; limit+1 on timeout.
    task automatic wait_result(input int limit, output int lat);
        lat = limit + 1;
        for (int n = 1; n <= limit; n++) begin
            @(posedge clock_i);
            #1;
            if (ln_data_valid_o) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock_i);
            #1;
        end
    endtask

    initial begin
        int lat;
        int pulses;
        logic [15:0] pdat;

        // Reset state
        step(3);
        check("rst_data", ln_data_o, 16'h0000);
        check("rst_valid", ln_data_valid_o, 1'b0);
        check("rst_done", ln_done_o, 1'b0);
        check("rst_busy", ln_busy_o, 1'b0);
        reset_i = 1'b0;
        step(1);

        // 1.0 -> 0, latency 14
        send(24'h010000);
        check("one_busy", ln_busy_o, 1'b1);
        wait_result(30, lat);
        check("one_lat", lat, 14);
        check("one_data", ln_data_o, 16'h0000);
        check("one_done", ln_done_o, 1'b1);
        check("one_busy_fall", ln_busy_o, 1'b0);
        step(1);
        check("one_pulse_len", ln_data_valid_o, 1'b0);

        // e -> 1.0
        send(24'h02B7E1);
        wait_result(30, lat);
        check("e_lat", lat, 14);
        check("e_data", ln_data_o, 16'h0100, 1);
        step(3);
        check("e_hold", ln_data_o, 16'h0100, 1);

        // Smallest non-zero input
        send(24'h000001);
        wait_result(30, lat);
        check("min_data", ln_data_o, 16'hF4E9, 1);

        // Largest input
        send(24'hFFFFFF);
        wait_result(30, lat);
        check("max_data", ln_data_o, EXP_FULL, 1);

        // Zero input saturates after 2 cycles
        step(1);
        send(24'h000000);
        wait_result(30, lat);
        check("zero_lat", lat, 2);
        check("zero_data", ln_data_o, 16'h8000);
        check("zero_busy", ln_busy_o, 1'b0);
        step(1);
        check("zero_busy_next", ln_busy_o, 1'b0);

        // Second input while busy is ignored
        send(24'h010000);
        step(2);
        send(24'h02B7E1);
        pulses = 0;
        pdat = 16'hFFFF;
        lat = 0;
        for (int n = 4; n <= 24; n++) begin
            @(posedge clock_i);
            #1;
            if (ln_data_valid_o) begin
                pulses++;
                lat  = n;
                pdat = ln_data_o;
            end
        end
        check("busy_pulses", pulses, 1);
        check("busy_lat", lat, 14);
        check("busy_data", pdat, 16'h0000);

        // Input one cycle after busy falls is accepted
        send(24'hFFFFFF);
        wait_result(30, lat);
        step(1);
        send(24'h010000);
        wait_result(30, lat);
        check("next_lat", lat, 14);
        check("next_data", ln_data_o, 16'h0000);

        // Reset during the fifth iteration aborts the operation
        send(24'hFFFFFF);
        wait_result(30, lat);
        step(1);
        send(24'h02B7E1);
        step(5);
        reset_i = 1'b1;
        step(1);
        reset_i = 1'b0;
        check("abort_data", ln_data_o, 16'h0000);
        check("abort_valid", ln_data_valid_o, 1'b0);
        check("abort_done", ln_done_o, 1'b0);
        check("abort_busy", ln_busy_o, 1'b0);
        send(24'h010000);
        wait_result(30, lat);
        check("post_rst_lat", lat, 14);
        check("post_rst_data", ln_data_o, 16'h0000);
        check("post_rst_done", ln_done_o, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
